// File: rtl/hc595_seg_pkg.sv
// Shared types and constants for the 74HC595 seven-segment scan driver:
// hex-to-segment table (active-high, a = bit 0), FSM state enum, blank pattern.
package hc595_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry n is the {dp,g,f,e,d,c,b,a} pattern for hex digit n, dp cleared.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/hc595_seg_scan_hex2seg.sv
// hex2seg: combinational nibble + decimal point to segment byte {dp,g..a}.
// A blanked digit shows no segments but still honours its decimal point.
// ACTIVE_LOW inverts the final byte for common-anode displays.
module hex2seg
    import hc595_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] pattern;

    // Table lookup, dp overlay, then polarity.
    always_comb begin
        pattern    = blank ? SEG_BLANK : HEX_SEG[nibble];
        pattern[7] = dp;
        seg        = ACTIVE_LOW ? ~pattern : pattern;
    end

endmodule

// File: rtl/hc595_seg_scan.sv
// hc595_seg_scan: multiplexed seven-segment driver for a 74HC595 chain.
// Per digit slot it shifts {segment byte, one-hot select field} MSB first
// over data_ser/srclk, then pulses rclk to latch it into the 595 outputs.
// Optional build macro HC595_SEG_BLANK_EN: leading-zero blanking.
//
// Handshake: a word transfers on any sys_clk edge where data_valid and
// data_ready are both 1. data_ready is 1 exactly when the pending register is
// empty; the pending word moves to the display register at the frame boundary
// (digit index wrapping DIGITS-1 -> 0), and data_ready rises the cycle after.
module hc595_seg_scan
    import hc595_seg_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int SRCLK_DIV      = 2,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  data_ser,
    output logic                  srclk,
    output logic                  rclk,
    output logic                  frame_done,
    output state_t                dbg_state
);

    localparam int W       = 8 + DIGITS;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W   = $clog2(W);
    localparam int MAX_DIV = (SCAN_DIV > SRCLK_DIV) ? SCAN_DIV : SRCLK_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV) + 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SRCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    // FSM and shifter state
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n;
    logic               phase_hi, phase_n;
    logic [W-1:0]       shreg, shreg_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               srclk_n, rclk_n, frame_done_n;
    logic               boundary;

    // Display and pending registers
    logic [4*DIGITS-1:0] active_data, pend_data;
    logic [DIGITS-1:0]   active_dp, pend_dp;
    logic                pend_full, pend_full_n;
    logic                take;

    // Current-digit decode
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [7:0]          seg_byte;
    logic [DIGITS-1:0]   sel_field;
    logic [W-1:0]        load_word;

    assign cur_nib = active_data[{idx, 2'b00} +: 4];
    assign cur_dp  = active_dp[idx];

`ifdef HC595_SEG_BLANK_EN
    logic nonzero_here_or_above;

    // Blank a digit when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        nonzero_here_or_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && active_data[4*i +: 4] != 4'h0) begin
                nonzero_here_or_above = 1'b1;
            end
        end
        cur_blank = (idx != '0) && !nonzero_here_or_above;
    end
`else
    assign cur_blank = 1'b0;
`endif

    hex2seg #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_hex2seg (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (seg_byte)
    );

    // One-hot select for the current digit, then the full shift word.
    always_comb begin
        sel_field = DIGITS'(1) << idx;
        if (SEL_ACTIVE_LOW) begin
            sel_field = ~sel_field;
        end
        load_word = {seg_byte, sel_field};
    end

    // The serial line is simply the shifter MSB, so it only moves when the
    // shifter does: on LOAD and on each srclk falling step.
    assign data_ser  = shreg[W-1];
    assign dbg_state = state;

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_n        = bit_cnt;
        phase_n      = phase_hi;
        shreg_n      = shreg;
        idx_n        = idx;
        srclk_n      = srclk;
        rclk_n       = rclk;
        frame_done_n = 1'b0;
        boundary     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cnt == SCAN_LAST) begin
                    state_n = ST_LOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_LOAD: begin
                state_n = ST_SHIFT;
                shreg_n = load_word;
                cnt_n   = '0;
                bit_n   = '0;
                phase_n = 1'b0;
                srclk_n = 1'b0;
            end
            ST_SHIFT: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!phase_hi) begin
                        phase_n = 1'b1;
                        srclk_n = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_n = ST_LATCH;
                        phase_n = 1'b0;
                        srclk_n = 1'b0;
                        rclk_n  = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        phase_n = 1'b0;
                        srclk_n = 1'b0;
                        shreg_n = {shreg[W-2:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_LATCH: begin
                if (cnt == HALF_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    rclk_n  = 1'b0;
                    if (idx == IDX_LAST) begin
                        idx_n        = '0;
                        boundary     = 1'b1;
                        frame_done_n = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Scan FSM registers and registered 595 pin outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            phase_hi   <= 1'b0;
            shreg      <= '0;
            idx        <= '0;
            srclk      <= 1'b0;
            rclk       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_n;
            phase_hi   <= phase_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            srclk      <= srclk_n;
            rclk       <= rclk_n;
            frame_done <= frame_done_n;
        end
    end

    // A transfer can only happen into an empty pending slot, so capture and
    // the boundary move never fight over the same word.
    always_comb begin
        take        = data_valid && data_ready;
        pend_full_n = pend_full;
        if (boundary) begin
            pend_full_n = 1'b0;
        end
        if (take) begin
            pend_full_n = 1'b1;
        end
    end

    // Pending capture, frame-boundary hand-over and registered ready.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pend_full   <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            active_data <= '0;
            active_dp   <= '0;
            data_ready  <= 1'b0;
        end else begin
            if (boundary && pend_full) begin
                active_data <= pend_data;
                active_dp   <= pend_dp;
            end
            if (take) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            pend_full  <= pend_full_n;
            data_ready <= !pend_full_n;
        end
    end

endmodule

// File: tb/tb_hc595_seg_scan.sv
// Self-checking bench for hc595_seg_scan at default parameters.
// A monitor rebuilds each latched 595 word from data_ser/srclk/rclk; the
// scoreboard compares those words and rclk timing against hand-written frames.
module tb_hc595_seg_scan;
    import hc595_seg_pkg::*;

    localparam int DIGITS     = 8;
    localparam int SRCLK_DIV  = 2;
    localparam int SCAN_DIV   = 1000;
    localparam int W          = 16;
    // 1000 idle + 1 load + 2*2*16 shift + 2 latch
    localparam int PERIOD     = 1067;
    // rclk rises after idle + load + shift
    localparam int FIRST_RCLK = 1065;

    // Hand-decoded frames, digit 0 first: {inverted seg byte, one-hot select}.
    localparam logic [W-1:0] FRAMES [4][8] = '{
        // all zeros after reset
        '{16'hC001, 16'hC002, 16'hC004, 16'hC008, 16'hC010, 16'hC020, 16'hC040, 16'hC080},
        // 0x12345678
        '{16'h8001, 16'hF802, 16'h8204, 16'h9208, 16'h9910, 16'hB020, 16'hA440, 16'hF980},
        // 0x87654321
        '{16'hF901, 16'hA402, 16'hB004, 16'h9908, 16'h9210, 16'h8220, 16'hF840, 16'h8080},
`ifdef HC595_SEG_BLANK_EN
        // 0x00000050, dp 0x22, leading zeros blanked
        '{16'hC001, 16'h1202, 16'hFF04, 16'hFF08, 16'hFF10, 16'h7F20, 16'hFF40, 16'hFF80}
`else
        // 0x00000050, dp 0x22, every digit shown
        '{16'hC001, 16'h1202, 16'hC004, 16'hC008, 16'hC010, 16'h4020, 16'hC040, 16'hC080}
`endif
    };

    // ---------------- clock / reset / DUT ----------------
    logic                sys_clk = 1'b0;
    logic                rst = 1'b1;
    logic [4*DIGITS-1:0] data_in = '0;
    logic [DIGITS-1:0]   dp_in = '0;
    logic                data_valid = 1'b0;
    logic                data_ready, data_ser, srclk, rclk, frame_done;
    state_t              dbg_state;

    always #5 sys_clk = ~sys_clk;

    hc595_seg_scan #(
        .DIGITS         (DIGITS),
        .SRCLK_DIV      (SRCLK_DIV),
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .SEL_ACTIVE_LOW (1'b0)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_ser   (data_ser),
        .srclk      (srclk),
        .rclk       (rclk),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int             cyc = 0;
    int             nb = 0;
    int             hi_len = 0;
    int             hi_err = 0;
    int             ser_err = 0;
    int             fd_count = 0;
    logic [W-1:0]   sh = '0;
    logic           p_srclk = 1'b0;
    logic           p_rclk = 1'b0;
    logic           p_ser = 1'b0;
    logic [W-1:0]   got_q[$];
    int             got_nb_q[$];
    int             got_cyc_q[$];

    // Sample #1 after each rising edge; rebuild words the way a 595 chain would.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (rst) begin
                nb     = 0;
                sh     = '0;
                hi_len = 0;
            end else begin
                if (srclk && data_ser !== p_ser) ser_err++;
                if (srclk && !p_srclk) begin
                    sh = {sh[W-2:0], data_ser};
                    nb++;
                end
                if (srclk) hi_len++;
                if (!srclk && p_srclk) begin
                    if (hi_len != SRCLK_DIV) hi_err++;
                    hi_len = 0;
                end
                if (rclk && !p_rclk) begin
                    got_q.push_back(sh);
                    got_nb_q.push_back(nb);
                    got_cyc_q.push_back(cyc);
                    nb = 0;
                end
                if (frame_done) fd_count++;
            end
            p_srclk = srclk;
            p_rclk  = rclk;
            p_ser   = data_ser;
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           rel_cyc = 0;
    int           last_rclk = -1;

    task automatic push(input int f, input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(FRAMES[f][i]);
    endtask

    task automatic drain(input string tag);
        int           budget;
        int           c;
        logic [W-1:0] g;
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            budget = 2 * PERIOD;
            while (got_q.size() == 0 && budget > 0) begin
                @(negedge sys_clk);
                budget--;
            end
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({tag, " word timeout"}, 32'(got_q.size()), 32'd1);
                exp_q.delete();
            end else begin
                g = got_q.pop_front();
                c = got_cyc_q.pop_front();
                check({tag, " word"}, 32'(g), 32'(e));
                check({tag, " bits per latch"}, 32'(got_nb_q.pop_front()), 32'(W));
                if (last_rclk < 0) check({tag, " first rclk"}, 32'(c - rel_cyc), 32'(FIRST_RCLK));
                else               check({tag, " rclk spacing"}, 32'(c - last_rclk), 32'(PERIOD));
                last_rclk = c;
            end
        end
    endtask

    task automatic wait_frame_done(input string tag, input logic exp_ready);
        int budget = 20;
        while (!frame_done && budget > 0) begin
            @(negedge sys_clk);
            budget--;
        end
        check({tag, " frame_done seen"}, 32'(frame_done), 32'd1);
        if (frame_done) begin
            check({tag, " frame_done delay"}, 32'(cyc - last_rclk), 32'(SRCLK_DIV));
            check({tag, " ready after boundary"}, 32'(data_ready), 32'(exp_ready));
        end
        @(negedge sys_clk);
        check({tag, " frame_done single cycle"}, 32'(frame_done), 32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic offer(input logic [31:0] d, input logic [7:0] dp);
        data_in    = d;
        dp_in      = dp;
        data_valid = 1'b1;
        @(negedge sys_clk);
        data_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge sys_clk);
        check("reset data_ready", 32'(data_ready), 32'd0);
        check("reset data_ser", 32'(data_ser), 32'd0);
        check("reset srclk", 32'(srclk), 32'd0);
        check("reset rclk", 32'(rclk), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        rst       = 1'b0;
        rel_cyc   = cyc;
        last_rclk = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int budget;

        do_reset(5);
        @(negedge sys_clk);
        check("ready after reset", 32'(data_ready), 32'd1);

        // Word A goes to pending; frame 1 still shows the reset zeros.
        offer(32'h1234_5678, 8'h00);
        check("ready low after capture A", 32'(data_ready), 32'd0);

        budget = 2000;
        while (cyc != rel_cyc + SCAN_DIV && budget > 0) begin
            @(negedge sys_clk);
            budget--;
        end
        check("first LOAD timing", 32'(dbg_state), 32'(ST_LOAD));

        push(0, 0, 7);
        drain("frame1 zeros");
        check("ready low before boundary 1", 32'(data_ready), 32'd0);
        wait_frame_done("boundary1", 1'b1);

        // Frame 2 shows A; B arrives mid-frame, then a back-to-back word is refused.
        push(1, 0, 2);
        drain("frame2 A head");
        repeat ($urandom_range(10, 200)) @(negedge sys_clk);
        check("ready before B", 32'(data_ready), 32'd1);
        offer(32'h8765_4321, 8'h00);
        data_in    = 32'hDEAD_BEEF;
        dp_in      = 8'hFF;
        data_valid = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("ready low while pending full", 32'(data_ready), 32'd0);
        data_valid = 1'b0;
        push(1, 3, 7);
        drain("frame2 A tail");
        check("ready low before boundary 2", 32'(data_ready), 32'd0);
        wait_frame_done("boundary2", 1'b1);

        // Frame 3 shows B; C (blanking pattern with dps) arrives mid-frame.
        push(2, 0, 1);
        drain("frame3 B head");
        offer(32'h0000_0050, 8'h22);
        check("ready low after capture C", 32'(data_ready), 32'd0);
        push(2, 2, 7);
        drain("frame3 B tail");
        wait_frame_done("boundary3", 1'b1);

        // Frame 4 shows C; nothing pending so ready stays high.
        push(3, 0, 7);
        drain("frame4 C");
        wait_frame_done("boundary4", 1'b1);

        // Reset while shifting bit 7 of the next digit 0.
        budget = 2 * PERIOD;
        while (!(nb == 7 && !srclk && dbg_state == ST_SHIFT) && budget > 0) begin
            @(negedge sys_clk);
            budget--;
        end
        check("reached shift bit 7", 32'(nb), 32'd7);
        rst = 1'b1;
        @(negedge sys_clk);
        check("mid reset data_ser", 32'(data_ser), 32'd0);
        check("mid reset srclk", 32'(srclk), 32'd0);
        check("mid reset rclk", 32'(rclk), 32'd0);
        check("mid reset data_ready", 32'(data_ready), 32'd0);
        check("mid reset state", 32'(dbg_state), 32'(ST_IDLE));
        check("no latch from partial frame", 32'(got_q.size()), 32'd0);
        do_reset(1);
        push(0, 0, 1);
        drain("after mid reset");

        check("srclk high width", 32'(hi_err), 32'd0);
        check("data_ser stable while srclk high", 32'(ser_err), 32'd0);
        check("frame_done pulse count", 32'(fd_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global bound in case a wait above never resolves.
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
